fft_frame_ctrl: RTL and testbench

// Frame scheduler for the ADC -> window -> FFT chain. Arms the sampler with
// a start pulse, counts accepted samples, and waits for the FFT result frame
// to drain. It then applies a programmable hold-off and re-arms (continuous

---
 rtl/fft_frame_if.sv | 26 ++
 rtl/fft_frame_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_fft_frame_ctrl.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_frame_if.sv
// Sampler / FFT stream side of the frame scheduler.
// The master drives the streams and the slave (the scheduler) drives the sampler strobes.
interface fft_frame_if;
  logic               i_samp_valid;
  logic               i_samp_ready;
  logic signed [11:0] i_samp_data;
  logic signed [11:0] i_trig_level;
  logic               i_fft_vld;
  logic               i_fft_last;
  logic               o_adc_valid;
  logic               o_adc_last;

  modport master (
    output i_samp_valid, i_samp_ready,
    output i_samp_data, i_trig_level,
    output i_fft_vld, i_fft_last,
    input  o_adc_valid, o_adc_last
  );

  modport slave (
    input  i_samp_valid, i_samp_ready,
    input  i_samp_data, i_trig_level,
    input  i_fft_vld, i_fft_last,
    output o_adc_valid, o_adc_last
  );
endinterface

// File: rtl/fft_frame_ctrl.sv
// Frame scheduler: arm, capture, drain, hold-off, re-arm for ADC->FFT.
// Optional TRIGGER_LEVEL_EN: ARM waits for a rising level crossing.
module fft_frame_ctrl #(
  parameter int FFT_LEN = 2048,
  parameter int CNT_W   = 11,
  parameter int TIMEOUT = 65535
) (
  input  logic        i_aclk,
  input  logic        i_aresetn,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic        i_cont,
  input  logic [15:0] i_holdoff,
  fft_frame_if.slave  bus,
  output logic        o_busy,
  output logic        o_frame_done,
  output logic [15:0] o_frame_cnt,
  output logic        o_timeout
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_CAPT,
    S_DRAIN,
    S_HOLD
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [15:0]       hold_q, hold_d;
  logic [15:0]       fcnt_q, fcnt_d;
  logic              tmo_q, tmo_d;
  logic              vld_q, vld_d;
  logic              last_q, last_d;
  logic              done_q, done_d;
  logic              acc;
  logic              fft_end;
  logic              hold_end;
  logic              trig_hit;

  assign acc      = bus.i_samp_valid & bus.i_samp_ready;
  assign fft_end  = bus.i_fft_vld & bus.i_fft_last;
  assign hold_end = ({1'b0, hold_q} + 17'd1) >= {1'b0, i_holdoff};

`ifdef TRIGGER_LEVEL_EN
  logic signed [11:0] prev_q, prev_d;
  logic               pvld_q, pvld_d;

  // No previous sample yet counts as "below level".
  assign trig_hit = acc
    && (!pvld_q || ($signed(prev_q) < $signed(bus.i_trig_level)))
    && ($signed(bus.i_samp_data) >= $signed(bus.i_trig_level));

  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      prev_q <= '0;
      pvld_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
      pvld_q <= pvld_d;
    end
  end
`else
  logic unused_trig;
  assign unused_trig = ^{bus.i_samp_data, bus.i_trig_level};
  assign trig_hit    = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wd_d    = wd_q;
    hold_d  = hold_q;
    fcnt_d  = fcnt_q;
    tmo_d   = tmo_q;
    vld_d   = 1'b0;
    last_d  = 1'b0;
    done_d  = 1'b0;
`ifdef TRIGGER_LEVEL_EN
    prev_d  = prev_q;
    pvld_d  = pvld_q;
`endif
    if (i_abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      wd_d    = '0;
      hold_d  = '0;
      last_d  = (state_q == S_CAPT);
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (i_start && !i_abort) begin
            state_d = S_ARM;
            tmo_d   = 1'b0;
            fcnt_d  = '0;
          end
        end
        S_ARM: begin
`ifdef TRIGGER_LEVEL_EN
          if (acc) begin
            prev_d = bus.i_samp_data;
            pvld_d = 1'b1;
          end
`endif
          if (trig_hit) begin
            state_d = S_CAPT;
            vld_d   = 1'b1;
          end
        end
        S_CAPT: begin
          if (acc) begin
            if (cnt_q == CNT_W'(FFT_LEN - 1)) begin
              cnt_d   = '0;
              wd_d    = '0;
              state_d = S_DRAIN;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (fft_end) begin
            done_d = 1'b1;
            fcnt_d = fcnt_q + 16'd1;
            wd_d   = '0;
            hold_d = '0;
            if (i_holdoff != 16'd0) state_d = S_HOLD;
            else if (i_cont)        state_d = S_ARM;
            else                    state_d = S_IDLE;
          end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
            tmo_d   = 1'b1;
            wd_d    = '0;
            state_d = S_IDLE;
          end else begin
            wd_d = wd_q + 1'b1;
          end
        end
        S_HOLD: begin
          if (hold_end) begin
            hold_d  = '0;
            state_d = i_cont ? S_ARM : S_IDLE;
          end else begin
            hold_d = hold_q + 16'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
`ifdef TRIGGER_LEVEL_EN
    if ((state_d == S_ARM) && (state_q != S_ARM)) pvld_d = 1'b0;
`endif
  end

  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wd_q    <= '0;
      hold_q  <= '0;
      fcnt_q  <= '0;
      tmo_q   <= 1'b0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
      hold_q  <= hold_d;
      fcnt_q  <= fcnt_d;
      tmo_q   <= tmo_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  assign o_busy         = (state_q != S_IDLE);
  assign o_frame_done   = done_q;
  assign o_frame_cnt    = fcnt_q;
  assign o_timeout      = tmo_q;
  assign bus.o_adc_valid = vld_q;
  assign bus.o_adc_last  = last_q;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for fft_frame_ctrl with FFT_LEN=16, TIMEOUT=100.
// Same vectors run in both builds; trigger vectors only with TRIGGER_LEVEL_EN.
module tb_fft_frame_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic        cont;
  logic [15:0] holdoff;
  logic        busy;
  logic        done;
  logic [15:0] fcnt;
  logic        tmo;
  int          n_cmp;
  int          n_err;

  fft_frame_if bus ();

  fft_frame_ctrl #(
    .FFT_LEN (16),
    .CNT_W   (4),
    .TIMEOUT (100)
  ) dut (
    .i_aclk       (clk),
    .i_aresetn    (rst_n),
    .i_start      (start),
    .i_abort      (abort),
    .i_cont       (cont),
    .i_holdoff    (holdoff),
    .bus          (bus.slave),
    .o_busy       (busy),
    .o_frame_done (done),
    .o_frame_cnt  (fcnt),
    .o_timeout    (tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    cont = 1'b0;
    holdoff = 16'd0;
    bus.i_samp_valid = 1'b0;
    bus.i_samp_ready = 1'b0;
    bus.i_samp_data = 12'sd0;
    bus.i_trig_level = 12'sd0;
    bus.i_fft_vld = 1'b0;
    bus.i_fft_last = 1'b0;
    tick();
    tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_adc_valid", int'(bus.o_adc_valid), 0);
    chk("rst_adc_last", int'(bus.o_adc_last), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_fcnt", int'(fcnt), 0);
    chk("rst_tmo", int'(tmo), 0);
    rst_n = 1'b1;
    tick();

    // single frame, valid&ready constant
    bus.i_samp_valid = 1'b1;
    bus.i_samp_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t1_arm_busy", int'(busy), 1);
    chk("t1_arm_adcv", int'(bus.o_adc_valid), 0);
    tick();
    chk("t1_capt_adcv", int'(bus.o_adc_valid), 1);
    tick();
    chk("t1_adcv_pulse", int'(bus.o_adc_valid), 0);
    repeat (14) tick();
    bus.i_fft_vld = 1'b1;
    bus.i_fft_last = 1'b1;
    tick();
    chk("t1_last_in_capt", int'(done), 0);
    chk("t1_cnt_in_capt", int'(fcnt), 0);
    tick();
    bus.i_fft_vld = 1'b0;
    bus.i_fft_last = 1'b0;
    chk("t1_done", int'(done), 1);
    chk("t1_fcnt", int'(fcnt), 1);
    chk("t1_idle", int'(busy), 0);
    tick();
    chk("t1_done_pulse", int'(done), 0);

    // ready toggling: 16 accepts in 31 capture cycles
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("t2_capt_adcv", int'(bus.o_adc_valid), 1);
    for (int i = 1; i <= 30; i++) begin
      bus.i_samp_ready = i[0];
      tick();
    end
    bus.i_samp_ready = 1'b1;
    bus.i_fft_vld = 1'b1;
    bus.i_fft_last = 1'b1;
    tick();
    chk("t2_still_capt", int'(done), 0);
    tick();
    bus.i_fft_vld = 1'b0;
    bus.i_fft_last = 1'b0;
    chk("t2_done", int'(done), 1);
    chk("t2_fcnt", int'(fcnt), 1);

    // continuous, holdoff 5, three frames
    cont = 1'b1;
    holdoff = 16'd5;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("t3_capt_adcv", int'(bus.o_adc_valid), 1);
    for (int f = 1; f <= 3; f++) begin
      repeat (15) tick();
      tick();
      bus.i_fft_vld = 1'b1;
      bus.i_fft_last = 1'b1;
      tick();
      bus.i_fft_vld = 1'b0;
      bus.i_fft_last = 1'b0;
      chk("t3_done", int'(done), 1);
      chk("t3_fcnt", int'(fcnt), f);
      if (f < 3) begin
        repeat (5) tick();
        chk("t3_arm_adcv", int'(bus.o_adc_valid), 0);
        tick();
        chk("t3_recapt_adcv", int'(bus.o_adc_valid), 1);
      end
    end
    cont = 1'b0;
    repeat (4) tick();
    chk("t3_hold_busy", int'(busy), 1);
    tick();
    chk("t3_single_idle", int'(busy), 0);
    chk("t3_final_fcnt", int'(fcnt), 3);

    // abort at beat 7 of capture
    holdoff = 16'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    repeat (6) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t4_adc_last", int'(bus.o_adc_last), 1);
    chk("t4_idle", int'(busy), 0);
    chk("t4_fcnt", int'(fcnt), 0);
    tick();
    chk("t4_last_pulse", int'(bus.o_adc_last), 0);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("t4_abort_wins", int'(busy), 0);
    tick();
    chk("t4_stay_idle", int'(busy), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t4_arm_abort_idle", int'(busy), 0);
    chk("t4_arm_abort_nolast", int'(bus.o_adc_last), 0);

    // watchdog at 100 drain cycles
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    repeat (15) tick();
    tick();
    repeat (99) tick();
    chk("t5_pre_tmo", int'(tmo), 0);
    chk("t5_pre_busy", int'(busy), 1);
    tick();
    chk("t5_tmo", int'(tmo), 1);
    chk("t5_tmo_idle", int'(busy), 0);
    tick();
    chk("t5_sticky", int'(tmo), 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t5_cleared", int'(tmo), 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5_abort_idle", int'(busy), 0);

`ifdef TRIGGER_LEVEL_EN
    bus.i_trig_level = 12'sd0;
    bus.i_samp_data = -12'sd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("t6_m5_adcv", int'(bus.o_adc_valid), 0);
    chk("t6_m5_busy", int'(busy), 1);
    bus.i_samp_data = -12'sd1;
    tick();
    chk("t6_m1_adcv", int'(bus.o_adc_valid), 0);
    bus.i_samp_data = 12'sd3;
    tick();
    chk("t6_p3_adcv", int'(bus.o_adc_valid), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t6_abort_last", int'(bus.o_adc_last), 1);
    bus.i_samp_data = 12'sd0;
`endif

    // async reset mid-frame
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_rst_idle", int'(busy), 0);
    chk("t7_rst_nolast", int'(bus.o_adc_last), 0);
    tick();
    chk("t7_rst_hold_last", int'(bus.o_adc_last), 0);
    rst_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
